// File: rtl/jk_seq_ctrl.sv
// Serial pattern detector that drives J/K excitation for a downstream flag flop.
// A match sets the flag (J); an acknowledge clears it (K), deferred one cycle if it collides with a match.
//
// state | meaning
// ------+---------------------------------------------
// S0    | no prefix of PATTERN seen
// S1    | first bit of PATTERN seen
// S11   | first two bits of PATTERN seen
// S110  | first three bits seen; next matching bit is a hit
// 4-7   | unused, forced back to S0 on the next edge
module jk_seq_ctrl #(
   parameter logic [3:0] PATTERN = 4'b1101
) (
   input  logic       clock,
   input  logic       clear_n,
   input  logic       enable,
   input  logic       bit_in,
   input  logic       ack_in,
   output logic [1:0] jk_out,
   output logic       detect,
   output logic [3:0] det_count,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      S0   = 3'd0,
      S1   = 3'd1,
      S11  = 3'd2,
      S110 = 3'd3
   } state_t;

   state_t     r_state;
   logic       r_pend_clr;
   logic [1:0] r_jk;
   logic       r_detect;
   logic [3:0] r_count;

   logic       w_valid;
   logic       w_match;
   logic [1:0] w_next_len;

   // Longest proper prefix of PATTERN that is a suffix of (matched prefix + new bit).
   function automatic logic [1:0] f_next(input logic [1:0] len, input logic b);
      logic [3:0] h;
      logic [1:0] nxt;
      case (len)
         2'd0:    h = {3'b000, b};
         2'd1:    h = {2'b00, PATTERN[3], b};
         2'd2:    h = {1'b0, PATTERN[3:2], b};
         default: h = {PATTERN[3:1], b};
      endcase
      nxt = 2'd0;
      if (h[0] == PATTERN[3]) nxt = 2'd1;
      if ((len >= 2'd1) && (h[1:0] == PATTERN[3:2])) nxt = 2'd2;
      if ((len >= 2'd2) && (h[2:0] == PATTERN[3:1])) nxt = 2'd3;
      return nxt;
   endfunction

   always_comb begin
      w_valid    = (r_state[2] == 1'b0);
      w_match    = enable && w_valid && (r_state[1:0] == 2'd3) && (bit_in == PATTERN[0]);
      w_next_len = f_next(r_state[1:0], bit_in);
   end

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         r_state    <= S0;
         r_pend_clr <= 1'b0;
         r_jk       <= 2'b00;
         r_detect   <= 1'b0;
         r_count    <= 4'h0;
      end else begin
         if (!w_valid)
            r_state <= S0;
         else if (enable)
            r_state <= state_t'({1'b0, w_next_len});

         r_detect <= w_match;
         if (w_match && (r_count != 4'hF))
            r_count <= r_count + 4'd1;

         // A set always wins; a clear that collides with it waits in r_pend_clr.
         if (w_match) begin
            r_jk       <= 2'b10;
            r_pend_clr <= r_pend_clr | ack_in;
         end else if (r_pend_clr || ack_in) begin
            r_jk       <= 2'b01;
            r_pend_clr <= 1'b0;
         end else begin
            r_jk       <= 2'b00;
         end
      end
   end

   assign jk_out    = r_jk;
   assign detect    = r_detect;
   assign det_count = r_count;
   assign state     = r_state;

endmodule

// File: tb/tb_jk_seq_ctrl.sv
// Self-checking bench for jk_seq_ctrl: a history-based reference model compared every cycle,
// plus hand-computed expectations for the directed scenarios.
module tb_jk_seq_ctrl;

   localparam logic [3:0] PAT = 4'b1101;

   logic       clock;
   logic       clear_n;
   logic       enable;
   logic       bit_in;
   logic       ack_in;
   logic [1:0] jk_out;
   logic       detect;
   logic [3:0] det_count;
   logic [2:0] state;

   int n_checks = 0;
   int n_errs   = 0;
   bit chk_on   = 0;

   // reference model state
   logic [3:0] m_hist;
   int         m_hlen;
   int         m_count;
   bit         m_pend;
   int         m_jk;
   int         m_det;
   int         m_state;

   jk_seq_ctrl #(.PATTERN(PAT)) dut (
      .clock     (clock),
      .clear_n   (clear_n),
      .enable    (enable),
      .bit_in    (bit_in),
      .ack_in    (ack_in),
      .jk_out    (jk_out),
      .detect    (detect),
      .det_count (det_count),
      .state     (state)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errs++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Longest suffix of the enabled-bit history (length < 4) that is a prefix of the pattern.
   function automatic int prefix_len(input logic [3:0] h, input int hl);
      int res;
      int hv;
      int pv;
      res = 0;
      hv  = int'(h);
      pv  = int'(PAT);
      for (int k = 1; k <= 3; k++)
         if (hl >= k && (hv % (1 << k)) == (pv >> (4 - k)))
            res = k;
      return res;
   endfunction

   always @(posedge clock or negedge clear_n) begin
      bit match;
      if (!clear_n) begin
         m_hist  = 4'h0;
         m_hlen  = 0;
         m_count = 0;
         m_pend  = 0;
         m_jk    = 0;
         m_det   = 0;
         m_state = 0;
      end else begin
         if (enable) begin
            m_hist = {m_hist[2:0], bit_in};
            if (m_hlen < 4) m_hlen++;
         end
         match = enable && (m_hlen == 4) && (m_hist == PAT);
         m_det = match ? 1 : 0;
         if (match && m_count < 15) m_count++;
         if (match) begin
            m_jk = 2;
            if (ack_in) m_pend = 1;
         end else if (m_pend || ack_in) begin
            m_jk   = 1;
            m_pend = 0;
         end else begin
            m_jk = 0;
         end
         m_state = prefix_len(m_hist, m_hlen);
      end
   end

   always @(negedge clock) begin
      if (chk_on) begin
         check("model_jk", int'(jk_out), m_jk);
         check("model_detect", int'(detect), m_det);
         check("model_count", int'(det_count), m_count);
         check("model_state", int'(state), m_state);
      end
   end

   task automatic step(input bit en, input bit b, input bit ack);
      enable = en;
      bit_in = b;
      ack_in = ack;
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      clear_n = 1'b0;
      @(posedge clock);
      #1;
      clear_n = 1'b1;
   endtask

   int pulses;
   int first_pulse;
   int gap;

   initial begin
      clear_n = 1'b0;
      enable  = 1'b0;
      bit_in  = 1'b0;
      ack_in  = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      check("rst_jk", int'(jk_out), 0);
      check("rst_detect", int'(detect), 0);
      check("rst_count", int'(det_count), 0);
      check("rst_state", int'(state), 0);
      clear_n = 1'b1;
      chk_on  = 1;

      // basic single match
      step(1, 1, 0); step(1, 1, 0); step(1, 0, 0); step(1, 1, 0);
      check("m1_detect", int'(detect), 1);
      check("m1_jk", int'(jk_out), 2);
      check("m1_count", int'(det_count), 1);
      check("m1_state", int'(state), 1);
      step(1, 0, 0);
      check("m1_detect_off", int'(detect), 0);
      check("m1_jk_off", int'(jk_out), 0);

      // overlapping matches
      do_reset();
      pulses = 0; first_pulse = -1; gap = -1;
      for (int i = 0; i < 7; i++) begin
         logic [6:0] s;
         s = 7'b1101101;
         step(1, s[6 - i], 0);
         if (detect) begin
            pulses++;
            if (first_pulse < 0) first_pulse = i;
            else gap = i - first_pulse;
         end
      end
      check("ovl_pulses", pulses, 2);
      check("ovl_gap", gap, 3);
      check("ovl_count", int'(det_count), 2);

      // match with simultaneous ack
      do_reset();
      step(1, 1, 0); step(1, 1, 0); step(1, 0, 0);
      step(1, 1, 1);
      check("pend_jk_set", int'(jk_out), 2);
      step(0, 0, 0);
      check("pend_jk_clr", int'(jk_out), 1);
      step(0, 0, 0);
      check("pend_jk_hold", int'(jk_out), 0);

      // ack alone
      step(0, 1, 1);
      check("ack_jk", int'(jk_out), 1);

      // enable freeze
      do_reset();
      step(1, 1, 0); step(1, 1, 0); step(1, 0, 0);
      for (int i = 0; i < 5; i++) begin
         step(0, i[0], 0);
         check("frz_state", int'(state), 3);
         check("frz_detect", int'(detect), 0);
      end
      step(1, 1, 0);
      check("frz_detect_hit", int'(detect), 1);
      check("frz_count", int'(det_count), 1);
      step(1, 0, 0);
      check("frz_single", int'(detect), 0);

      // saturation
      do_reset();
      step(1, 1, 0); step(1, 1, 0); step(1, 0, 0); step(1, 1, 0);
      for (int i = 0; i < 16; i++) begin
         step(1, 1, 0); step(1, 0, 0); step(1, 1, 0);
      end
      check("sat_count", int'(det_count), 15);

      // async reset mid-pattern with a pending clear
      step(1, 1, 0); step(1, 0, 0);
      step(1, 1, 1);
      #2;
      clear_n = 1'b0;
      #1;
      check("arst_jk", int'(jk_out), 0);
      check("arst_detect", int'(detect), 0);
      check("arst_count", int'(det_count), 0);
      check("arst_state", int'(state), 0);
      @(posedge clock);
      #1;
      clear_n = 1'b1;
      step(1, 0, 0);
      check("arst_no_pend", int'(jk_out), 0);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 299) == 0) begin
            do_reset();
         end else begin
            step(($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 4) == 0));
         end
      end

      chk_on = 0;
      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
